// File: rtl/lc3_pkg.sv
// lc3_pkg: memory FSM state type and MMIO register addresses shared by lc3_memory.
package lc3_pkg;
  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT} memState_t;
  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
endpackage

// File: rtl/lc3_mmio_regs.sv
// lc3_mmio_regs: keyboard/display register set, read mux and device handshakes.
module lc3_mmio_regs import lc3_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wchar,
  output logic [15:0] o_rdata,
  input  logic [7:0]  kbdChar,
  input  logic        kbdValid,
  output logic        kbdReady,
  output logic [7:0]  dispChar,
  output logic        dispValid,
  input  logic        dispReady
);
  logic       r_kbd_full, r_disp_valid;
  logic [7:0] r_kbd_data, r_disp_char;
  logic       w_kbd_load;
  assign w_kbd_load = kbdValid & ~r_kbd_full;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kbd_full   <= 1'b0;
      r_kbd_data   <= 8'h00;
      r_disp_valid <= 1'b0;
      r_disp_char  <= 8'h00;
    end else begin
      r_kbd_full <= w_kbd_load | (r_kbd_full & ~(i_rd && i_addr == ADDR_KBDR));
      if (w_kbd_load) r_kbd_data <= kbdChar;
      if (r_disp_valid) r_disp_valid <= ~dispReady;
      else if (i_wr && i_addr == ADDR_DDR) begin
        r_disp_valid <= 1'b1;
        r_disp_char  <= i_wchar;
      end
    end
  end
  always_comb
    o_rdata = i_addr == ADDR_KBSR ? {r_kbd_full, 15'b0} :
              i_addr == ADDR_KBDR ? {8'h00, r_kbd_data} :
              i_addr == ADDR_DSR  ? {~r_disp_valid, 15'b0} : {8'h00, r_disp_char};
  assign kbdReady  = ~r_kbd_full;
  assign dispValid = r_disp_valid;
  assign dispChar  = r_disp_char;
endmodule

// File: rtl/lc3_memory.sv
// lc3_memory: MAR/MDR memory responder with WAIT_STATES wait states and ready handshake.
// Define LC3_MMIO_EN to map the keyboard/display registers at x'FE00-x'FE06.
module lc3_memory import lc3_pkg::*; #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ldMAR,
  input  logic        ldMDR,
  input  logic        selMDR,
  input  logic        memWE,
  input  logic [15:0] busIn,
  output logic [15:0] mdrOut,
  output logic        memReady,
  input  logic [7:0]  kbdChar,
  input  logic        kbdValid,
  output logic        kbdReady,
  output logic [7:0]  dispChar,
  output logic        dispValid,
  input  logic        dispReady
);
  localparam bit ZW = WAIT_STATES == 0;
  memState_t   r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_mar, r_mdr, r_addr, r_wdata;
  logic [15:0] r_mem [2**ADDR_WIDTH];
  logic        w_rd_req, w_req, w_idle, w_commit_rd, w_commit_wr, w_is_mmio;
  logic [15:0] w_req_addr, w_c_addr, w_c_data, w_mmio_rdata, w_rdata;
  // With no wait states the access commits at the request edge from live MAR/MDR.
  always_comb begin
    w_rd_req    = ldMDR & selMDR;
    w_req       = w_rd_req | memWE;
    w_idle      = r_state == IDLE;
    w_req_addr  = ldMAR ? busIn : r_mar;
    w_commit_rd = ZW ? (w_idle & w_rd_req) : (r_state == READ_WAIT && r_cnt == 4'd0);
    w_commit_wr = ZW ? (w_idle & memWE & ~w_rd_req) : (r_state == WRITE_WAIT && r_cnt == 4'd0);
    w_c_addr    = ZW ? w_req_addr : r_addr;
    w_c_data    = ZW ? r_mdr : r_wdata;
    w_rdata     = w_is_mmio ? w_mmio_rdata : r_mem[w_c_addr[ADDR_WIDTH-1:0]];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_mar   <= 16'h0000;
      r_mdr   <= 16'h0000;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
    end else begin
      if (ldMAR) r_mar <= busIn;
      if (w_commit_rd) r_mdr <= w_rdata;
      else if (ldMDR & ~selMDR) r_mdr <= busIn;
      if (w_idle) begin
        if (w_req && !ZW) begin
          r_addr  <= w_req_addr;
          r_wdata <= r_mdr;
          r_cnt   <= 4'(WAIT_STATES - 1);
          r_state <= w_rd_req ? READ_WAIT : WRITE_WAIT;
        end
      end else if (r_cnt == 4'd0) r_state <= IDLE;
      else r_cnt <= r_cnt - 4'd1;
    end
  end
  always_ff @(posedge clk)
    if (w_commit_wr & ~w_is_mmio & ~reset) r_mem[w_c_addr[ADDR_WIDTH-1:0]] <= w_c_data;
  assign mdrOut   = r_mdr;
  assign memReady = w_idle;
`ifdef LC3_MMIO_EN
  assign w_is_mmio = (w_c_addr & 16'hFFF9) == ADDR_KBSR;
  lc3_mmio_regs u_mmio (
    .clk, .reset,
    .i_rd(w_commit_rd), .i_wr(w_commit_wr), .i_addr(w_c_addr), .i_wchar(w_c_data[7:0]),
    .o_rdata(w_mmio_rdata),
    .kbdChar, .kbdValid, .kbdReady, .dispChar, .dispValid, .dispReady
  );
`else
  logic w_unused;
  assign w_is_mmio    = 1'b0;
  assign w_mmio_rdata = 16'h0000;
  assign kbdReady     = 1'b0;
  assign dispValid    = 1'b0;
  assign dispChar     = 8'h00;
  assign w_unused     = ^{kbdChar, kbdValid, dispReady, w_c_addr};
`endif
endmodule

// File: tb/tb_lc3_memory.sv
// tb_lc3_memory: directed and randomized checks of lc3_memory against a transaction-level model.
module tb_lc3_memory;
  localparam int WS = 2;
`ifdef LC3_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, ldMAR, ldMDR, selMDR, memWE, kbdValid, dispReady;
  logic [15:0] busIn, mdrOut;
  logic [7:0]  kbdChar, dispChar;
  logic        memReady, kbdReady, dispValid;
  logic        z_reset, z_ldMAR, z_ldMDR, z_selMDR, z_memWE, z_ready, z_kr, z_dv;
  logic [15:0] z_bus, z_mdr;
  logic [7:0]  z_dc;
  int tests = 0, fails = 0;

  lc3_memory #(.ADDR_WIDTH(8), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .ldMAR(ldMAR), .ldMDR(ldMDR), .selMDR(selMDR), .memWE(memWE),
    .busIn(busIn), .mdrOut(mdrOut), .memReady(memReady), .kbdChar(kbdChar), .kbdValid(kbdValid),
    .kbdReady(kbdReady), .dispChar(dispChar), .dispValid(dispValid), .dispReady(dispReady));

  lc3_memory #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(z_reset), .ldMAR(z_ldMAR), .ldMDR(z_ldMDR), .selMDR(z_selMDR), .memWE(z_memWE),
    .busIn(z_bus), .mdrOut(z_mdr), .memReady(z_ready), .kbdChar(8'h00), .kbdValid(1'b0),
    .kbdReady(z_kr), .dispChar(z_dc), .dispValid(z_dv), .dispReady(1'b0));

  task automatic check(string nm, logic [15:0] got, logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level reference: a request starts a countdown of WS edges, then commits.
  logic [15:0] m_mem [256];
  bit          m_ok  [256];
  logic [15:0] e_mar, e_mdr, p_addr, p_data;
  logic [7:0]  e_kd, e_dc;
  bit          e_ok, p_ok, p_rd, e_full, e_dv, e_dcok, started = 1'b0;
  int          busy = 0;

  function automatic bit is_mmio(logic [15:0] a);
    return MMIO && (a == 16'hFE00 || a == 16'hFE02 || a == 16'hFE04 || a == 16'hFE06);
  endfunction

  task automatic commit(bit rd, logic [15:0] a, logic [15:0] d, bit dok, bit old_full, bit old_dv);
    int idx = int'(a) % 256;
    if (rd) begin
      if (!is_mmio(a)) begin e_mdr = m_mem[idx]; e_ok = m_ok[idx]; end
      else if (a == 16'hFE00) begin e_mdr = old_full ? 16'h8000 : 16'h0000; e_ok = 1; end
      else if (a == 16'hFE02) begin e_mdr = {8'h00, e_kd}; e_ok = 1; e_full = 0; end
      else if (a == 16'hFE04) begin e_mdr = old_dv ? 16'h0000 : 16'h8000; e_ok = 1; end
      else e_ok = 0;
    end else if (!is_mmio(a)) begin
      m_mem[idx] = d;
      m_ok[idx]  = dok;
    end else if (a == 16'hFE06 && !old_dv) begin
      e_dv = 1; e_dc = d[7:0]; e_dcok = dok;
    end
  endtask

  always @(posedge clk) begin : model
    bit rd, wr, of, odv, ook;
    logic [15:0] a, om;
    if (reset) begin
      e_mar = 0; e_mdr = 0; e_ok = 1; busy = 0;
      e_full = 0; e_kd = 0; e_dv = 0; e_dc = 0; e_dcok = 1; started = 1;
    end else begin
      of = e_full; odv = e_dv; om = e_mdr; ook = e_ok;
      rd = ldMDR && selMDR;
      wr = memWE && !rd;
      a = ldMAR ? busIn : e_mar;
      if (ldMAR) e_mar = busIn;
      if (ldMDR && !selMDR) begin e_mdr = busIn; e_ok = 1; end
      if (busy > 0) begin
        busy--;
        if (busy == 0) commit(p_rd, p_addr, p_data, p_ok, of, odv);
      end else if (rd || wr) begin
        busy = WS; p_rd = rd; p_addr = a; p_data = om; p_ok = ook;
      end
      if (MMIO && kbdValid && !of) begin e_full = 1; e_kd = kbdChar; end
      if (odv && dispReady) e_dv = 0;
    end
  end

  always @(negedge clk) if (started) begin
    check("memReady", memReady, busy == 0);
    if (e_ok) check("mdrOut", mdrOut, e_mdr);
    check("kbdReady", kbdReady, MMIO && !e_full);
    check("dispValid", dispValid, e_dv);
    if (e_dcok) check("dispChar", dispChar, e_dc);
  end

  task automatic cyc(bit lm, bit ld, bit sel, bit we, logic [15:0] b);
    ldMAR = lm; ldMDR = ld; selMDR = sel; memWE = we; busIn = b;
    @(negedge clk);
    ldMAR = 0; ldMDR = 0; memWE = 0;
  endtask

  task automatic zcyc(bit lm, bit ld, bit sel, bit we, logic [15:0] b);
    z_ldMAR = lm; z_ldMDR = ld; z_selMDR = sel; z_memWE = we; z_bus = b;
    @(negedge clk);
    z_ldMAR = 0; z_ldMDR = 0; z_memWE = 0;
  endtask

  task automatic write_word(logic [15:0] a, logic [15:0] d);
    cyc(1, 0, 0, 0, a);
    cyc(0, 1, 0, 0, d);
    cyc(0, 0, 0, 1, 16'h0000);
    repeat (WS) @(negedge clk);
  endtask

  task automatic read_word(logic [15:0] a);
    cyc(1, 1, 1, 0, a);
    repeat (WS) @(negedge clk);
  endtask

  logic [15:0] pool [11] = '{16'h0003, 16'h0103, 16'h0010, 16'h00FF, 16'h1FF0, 16'hFE00,
                             16'hFE02, 16'hFE04, 16'hFE06, 16'h0005, 16'h0000};

  initial begin
    reset = 1; ldMAR = 0; ldMDR = 0; selMDR = 0; memWE = 0; busIn = 0;
    kbdChar = 0; kbdValid = 0; dispReady = 0;
    z_reset = 1; z_ldMAR = 0; z_ldMDR = 0; z_selMDR = 0; z_memWE = 0; z_bus = 0;
    @(negedge clk); @(negedge clk);
    check("rst_mdr", mdrOut, 16'h0000);
    check("rst_ready", memReady, 1'b1);
    check("rst_kbdReady", kbdReady, MMIO);
    check("rst_dispValid", dispValid, 1'b0);
    z_reset = 0;
    zcyc(1, 0, 0, 0, 16'h0010);
    zcyc(0, 1, 0, 0, 16'h1234);
    zcyc(0, 1, 0, 1, 16'h0000);
    check("ws0_mdr_reloaded", z_mdr, 16'h0000);
    check("ws0_ready_wr", z_ready, 1'b1);
    zcyc(0, 1, 1, 0, 16'h0000);
    check("ws0_read", z_mdr, 16'h1234);
    check("ws0_ready_rd", z_ready, 1'b1);
    zcyc(0, 1, 0, 0, 16'hBEEF);
    zcyc(1, 0, 0, 1, 16'h0103);
    zcyc(1, 1, 1, 0, 16'h0003);
    check("ws0_alias", z_mdr, 16'hBEEF);
    check("ws0_nommio", {z_kr, z_dv, z_dc}, 16'h0000);
    reset = 0;
    cyc(1, 0, 0, 0, 16'h0005);
    cyc(0, 1, 0, 0, 16'hABCD);
    cyc(0, 0, 0, 1, 16'h0000);
    check("ws2_busy1", memReady, 1'b0);
    @(negedge clk);
    check("ws2_busy2", memReady, 1'b0);
    @(negedge clk);
    check("ws2_ready_back", memReady, 1'b1);
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(0, 1, 1, 0, 16'h0000);
    check("ws2_rd_edge0", mdrOut, 16'h0000);
    @(negedge clk);
    check("ws2_rd_edge1", mdrOut, 16'h0000);
    @(negedge clk);
    check("ws2_rd_edge2", mdrOut, 16'hABCD);
    write_word(16'h0103, 16'hBEEF);
    read_word(16'h0003);
    check("alias", mdrOut, 16'hBEEF);
    write_word(16'h0020, 16'h1111);
    cyc(1, 0, 0, 0, 16'h0020);
    cyc(0, 1, 0, 0, 16'h2222);
    cyc(0, 0, 0, 1, 16'h0000);
    cyc(0, 1, 0, 1, 16'h3333);
    @(negedge clk);
    check("busy_mdr_load", mdrOut, 16'h3333);
    read_word(16'h0020);
    check("busy_write_ignored", mdrOut, 16'h2222);
    write_word(16'h0030, 16'h4444);
    cyc(0, 1, 0, 0, 16'h5555);
    cyc(1, 0, 0, 1, 16'h0030);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("midrst_mdr", mdrOut, 16'h0000);
    check("midrst_ready", memReady, 1'b1);
    read_word(16'h0030);
    check("midrst_ram", mdrOut, 16'h4444);
`ifdef LC3_MMIO_EN
    kbdChar = 8'h41; kbdValid = 1;
    @(negedge clk);
    kbdValid = 0;
    check("kbd_full", kbdReady, 1'b0);
    read_word(16'hFE00);
    check("kbsr", mdrOut, 16'h8000);
    read_word(16'hFE02);
    check("kbdr", mdrOut, 16'h0041);
    check("kbd_empty", kbdReady, 1'b1);
    write_word(16'hFE06, 16'h0048);
    check("ddr_valid", dispValid, 1'b1);
    write_word(16'hFE06, 16'h0049);
    check("ddr_held", dispChar, 16'h0048);
    read_word(16'hFE04);
    check("dsr_busy", mdrOut, 16'h0000);
    dispReady = 1;
    @(negedge clk);
    dispReady = 0;
    check("disp_clear", dispValid, 1'b0);
    read_word(16'hFE04);
    check("dsr_ready", mdrOut, 16'h8000);
`else
    kbdChar = 8'h41; kbdValid = 1;
    @(negedge clk);
    kbdValid = 0;
    check("nommio_kbdReady", kbdReady, 1'b0);
    write_word(16'hFE06, 16'h5A5A);
    check("nommio_dispValid", dispValid, 1'b0);
    read_word(16'h0006);
    check("nommio_ram_alias", mdrOut, 16'h5A5A);
`endif
    foreach (pool[i]) write_word(pool[i], 16'($urandom));
    repeat (3000) begin
      reset     = ($urandom % 300) == 0;
      ldMAR     = ($urandom % 4) == 0;
      ldMDR     = ($urandom % 3) == 0;
      selMDR    = 1'($urandom);
      memWE     = ($urandom % 5) == 0;
      busIn     = ldMAR ? pool[$urandom % 11] : 16'($urandom);
      kbdValid  = ($urandom % 6) == 0;
      kbdChar   = 8'($urandom);
      dispReady = ($urandom % 3) == 0;
      @(negedge clk);
    end
    reset = 0; ldMAR = 0; ldMDR = 0; memWE = 0; kbdValid = 0;
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lc3_memory.md
# lc3_memory

Memory responder for the LC-3 datapath, on the far side of the controller's MAR/MDR memory interface. It holds MAR and MDR and a word-addressed RAM, and completes read and write requests after a configurable number of wait states, with a ready handshake back to the controller. An optional memory-mapped keyboard and display register set sits at the top of the address space.

## Interface
Parameters:
- ADDR_WIDTH, 8: RAM depth is 2^ADDR_WIDTH 16-bit words; MAR bits above ADDR_WIDTH are ignored for RAM indexing.
- WAIT_STATES, 2: extra cycles per RAM/MMIO access, range 0–15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ldMAR  in  1  MAR <= busIn.
- ldMDR  in  1  load MDR; the source is chosen by selMDR.
- selMDR  in  1  1: read request (MDR <= mem[MAR]); 0: MDR <= busIn, no memory access.
- memWE  in  1  write request (mem[MAR] <= MDR).
- busIn  in  16  datapath bus value.
- mdrOut  out  16  current MDR; gated onto the bus by enaMDR outside this block.
- memReady  out  1  1 when idle and able to accept a request.
- kbdChar  in  8  keyboard character. (MMIO)
- kbdValid  in  1  keyboard character strobe. (MMIO)
- kbdReady  out  1  keyboard register empty. (MMIO)
- dispChar  out  8  display character. (MMIO)
- dispValid  out  1  display character pending. (MMIO)
- dispReady  in  1  display accepts a character. (MMIO)

## Operation
- Request definitions:
  - A read request is ldMDR&selMDR.
  - A write request is memWE.
  - Both high in the same cycle is illegal; the read takes priority.
- State machine states are IDLE, READ_WAIT and WRITE_WAIT. memReady = (state==IDLE).
- IDLE behaviour:
  - On a request, the block latches addr=MAR, or busIn if ldMAR is high in the same cycle.
  - WAIT_STATES=0: the access commits at that edge and the state stays IDLE.
  - WAIT_STATES>0: the block loads cnt=WAIT_STATES-1 and moves to READ_WAIT or WRITE_WAIT.
- READ_WAIT and WRITE_WAIT behaviour:
  - cnt decrements each cycle.
  - At the edge where cnt==0, the access commits and the state returns to IDLE.
  - Requests while not IDLE are ignored and not queued.
- Commit:
  - A read commits MDR <= readData(addr).
  - A write commits store(addr, MDR value latched at request).
- Register loads while busy:
  - ldMAR loads MAR in any state.
  - ldMDR with selMDR=0 loads MDR in any state.
  - Neither affects an in-flight access.
  - A pending read commit overwrites MDR at its commit edge.
- RAM is indexed by addr[ADDR_WIDTH-1:0], so higher address bits alias (wrap).
- MMIO registers (compiled in, see Configuration):
  - KBSR x'FE00: bit15 = kbdFull; reads as {kbdFull,15'b0}.
  - KBDR x'FE02: reads as {8'h00,kbdData}; a read commit clears kbdFull.
  - DSR x'FE04: bit15 = ~dispValid.
  - DDR x'FE06:
    - A write commit with dispValid=0 sets dispChar=data[7:0] and dispValid=1.
    - A write commit with dispValid=1 drops the data.
  - Writes to KBSR, KBDR and DSR are ignored. MMIO addresses never touch RAM.
- Keyboard handshake:
  - kbdReady = ~kbdFull.
  - kbdValid&kbdReady latches kbdChar and sets kbdFull.
  - kbdValid while full is dropped.
  - A KBDR read commit and kbdValid in the same edge: the read returns the old char and clears the flag. The strobe is dropped because kbdReady was low.
- Display handshake: dispValid stays high until a cycle with dispReady=1, then clears at that edge.

## Timing
- Reset values:
  - MAR=0, MDR=0 (mdrOut=0), state=IDLE, memReady=1.
  - kbdFull=0 (kbdReady=1), kbdData=0.
  - dispValid=0, dispChar=0.
- RAM contents are not reset.
- Reset mid-access aborts the access: no RAM write occurs and MDR is 0.
- Latency:
  - Request at edge k: data is in MDR, or RAM is written, at edge k+WAIT_STATES.
  - memReady is low during cycles k+1 through k+WAIT_STATES.
- RAM is read and written synchronously at the commit edge; there is no combinational read path to mdrOut.

## Configuration
- LC3_MMIO_EN defined: KBSR/KBDR/DSR/DDR are decoded as above and the keyboard and display ports are live.
- LC3_MMIO_EN undefined:
  - Addresses x'FE00–x'FE06 are plain RAM (aliased).
  - kbdReady=0, dispValid=0, dispChar=0.
  - kbdChar, kbdValid and dispReady are ignored.
  - The ports remain present.

## Structure
- The lc3 package holds:
  - memState_t (IDLE, READ_WAIT, WRITE_WAIT).
  - Constants ADDR_KBSR, ADDR_KBDR, ADDR_DSR, ADDR_DDR.
- Sub-module lc3_mmio_regs, instantiated only under LC3_MMIO_EN, contains:
  - the KBSR/KBDR/DSR/DDR state;
  - the read mux;
  - the keyboard and display handshakes.

## Test plan
- Reset, WAIT_STATES=2:
  - Stimulus: ldMAR with busIn=x'0005; ldMDR selMDR=0 with busIn=x'ABCD; memWE.
  - Required: memReady low for 2 cycles.
  - Then: read request at x'0005.
  - Required: mdrOut=x'ABCD exactly 2 edges after the request.
- WAIT_STATES=0:
  - Stimulus: back-to-back write then read of x'0010=x'1234.
  - Required: memReady constant 1; mdrOut=x'1234 one edge after the read request.
- Aliasing (ADDR_WIDTH=8):
  - Stimulus: write x'0103=x'BEEF, then read x'0003.
  - Required: x'BEEF.
- Busy and reset:
  - Stimulus: a write request issued while memReady=0.
  - Required: ignored; RAM unchanged.
  - Stimulus: reset asserted mid-write.
  - Required: target word unchanged; mdrOut=0.
- MMIO keyboard:
  - Stimulus: kbdValid with kbdChar=x'41.
  - Required: KBSR read = x'8000.
  - Then: KBDR read.
  - Required: returns x'0041; kbdReady returns to 1.
- MMIO display:
  - Stimulus: DDR write x'0048 with dispReady=0, then a second DDR write x'0049.
  - Required: dispChar=x'48 held; DSR reads x'0000; second write dropped.
  - Then: dispReady=1 for one cycle.
  - Required: dispValid clears; DSR reads x'8000.
